// File: rtl/fetch_pcreg_pkg.sv
// Shared pipeline types for the fetch stage: state encoding, bus and decode records.
package fetch_pcreg_pkg;

    localparam logic [63:0] PC_RESET = 64'h8000_0000;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        HOLD,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_data_t;

endpackage

// File: rtl/fetch_pcreg_if.sv
// Instruction-bus request/response bundle between fetch (master) and memory (slave).
interface fetch_pcreg_if;

    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_pcreg.sv
// Fetch PC register: holds the architectural fetch PC, issues one instruction-bus
// request at a time and buffers a single returned instruction for decode.
module fetch_pcreg
    import fetch_pcreg_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [63:0]          pc_next,
    input  logic                 pc_move,
    input  logic                 redirect,
    fetch_pcreg_if.master        ibus,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [63:0]          dec_pc,
    output logic [31:0]          dec_instr,
    output logic                 dec_misalign,
    output logic                 stop_forfetch,
    output logic [63:0]          pc_stop,
    output logic [63:0]          pcplus4
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  req_addr_q, req_addr_d;
    fetch_data_t  buf_q, buf_d;
    ibus_req_t    req;
    ibus_resp_t   resp;
    logic         aligned;

    assign resp.data_ok    = ibus.iresp_data_ok;
    assign resp.data       = ibus.iresp_data;
    assign ibus.ireq_valid = req.valid;
    assign ibus.ireq_addr  = req.addr;

    assign aligned = (pc_q[1:0] == 2'b00);

    // State, PC, in-flight request address and decode buffer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
        end
    end

    // Next-state, PC select and bus request generation.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        req_addr_d = req_addr_q;
        req.valid  = 1'b0;
        req.addr   = req_addr_q;

        if ((state_q != BOOT) && pc_move &&
            (redirect || ((state_q == HOLD) && dec_ready))) begin
            pc_d = pc_next;
        end else begin
            pc_d = pc_q;
        end

        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (!aligned) begin
                    // A redirect arriving here replaces the bad PC, so the
                    // exception for the old PC is flushed rather than delivered.
                    if (!redirect) begin
                        state_d = HOLD;
                        buf_d   = '{valid: 1'b1, pc: pc_q, instr: '0, misalign: 1'b1};
                    end
                end else begin
                    req.valid  = 1'b1;
                    req.addr   = pc_q;
                    req_addr_d = pc_q;
                    if (resp.data_ok) begin
                        if (!redirect) begin
                            state_d = HOLD;
                            buf_d   = '{valid: 1'b1, pc: pc_q, instr: resp.data, misalign: 1'b0};
                        end
                    end else if (redirect) begin
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                req.valid = 1'b1;
                req.addr  = req_addr_q;
                if (resp.data_ok) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect || dec_ready) begin
                    state_d = REQ;
                    buf_d   = '0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign dec_valid     = buf_q.valid;
    assign dec_pc        = buf_q.pc;
    assign dec_instr     = buf_q.instr;
    assign dec_misalign  = buf_q.misalign;
    assign stop_forfetch = (state_q != HOLD);
    assign pc_stop       = pc_q;
    assign pcplus4       = pc_q + 64'd4;

endmodule
